fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the 5-stage RISC-V pipeline, replacing the bare PC register plus IF_ID latch. It owns the fetch PC, issues requests to the synchronous-read instruction memory, and buffers returned instructions with their PC and PC+4 in a DEPTH-entry queue feeding decode. It supports a decode-side back-pressure handshake and an execute-side redirect that flushes the queue and any in-flight fetch.

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues IMEM reads, queues {inst, pc} for decode.
// Latency: 2 cycles from im_req to id_valid; 1 instr/cycle sustained with id_ready held high.
// Backpressure: id_ready low holds the head; requests stop once queued + in-flight entries fill DEPTH.
//
// Ports: clk/rst (async active-high); loadIM freezes request issue;
//   im_req/im_addr/im_rdata talk to a synchronous-read IMEM (data one cycle after request);
//   redirect/redirect_pc flush the queue and any in-flight fetch and restart fetch;
//   id_valid/id_ready/id_inst/id_pc/id_pcadd4 present the queue head to decode.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched, perf_flushed and perf_stall counters.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            loadIM,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic [XLEN-1:0] im_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcadd4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_flushed,
  output logic [XLEN-1:0] perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];

  logic            pop;
  logic            push;
  logic [AW+1:0]   occ;
  logic            space;
  logic            unused_low_bits;

  // The low address bits of a redirect target are forced to zero.
  assign unused_low_bits = ^redirect_pc[1:0];

  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready;
  // A response is only accepted if no redirect kills it this cycle.
  assign push     = inflight && !redirect;

  // Issue rule: (count + inflight - pop) < DEPTH, rearranged so nothing underflows.
  assign occ   = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign space = pop ? (occ <= (AW+2)'(DEPTH)) : (occ < (AW+2)'(DEPTH));

  assign im_req  = !rst && !loadIM && !redirect && space;
  assign im_addr = fetch_pc;

  // Head fields read as zero while the queue is empty.
  assign id_inst   = id_valid ? mem_inst[rd_ptr] : '0;
  assign id_pc     = id_valid ? mem_pc[rd_ptr]   : '0;
  assign id_pcadd4 = id_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      // Flush wins over push, pop and issue.
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= wr_ptr;
      count    <= '0;
    end else begin
      // The IMEM always answers the cycle after a request, so inflight just tracks im_req.
      inflight <= im_req;
      if (im_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= im_rdata;
      mem_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + XLEN'(1);
      if (redirect) perf_flushed <= perf_flushed + XLEN'(count) + XLEN'(inflight);
      if (id_valid && !id_ready) perf_stall <= perf_stall + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a queue-level model.
// IMEM model returns word k = k (data = address >> 2) one cycle after a request.
// Inputs change 1 time unit after the rising edge; the model checks every falling edge.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loadIM = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst, id_pc, id_pcadd4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .loadIM(loadIM),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pcadd4(id_pcadd4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word k holds k.
  always @(posedge clk) if (im_req) im_rdata <= im_addr >> 2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic drive(input logic rs, input logic r, input logic rd, input logic ld,
                       input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst = rs; redirect = r; id_ready = rd; loadIM = ld; redirect_pc = rpc;
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_q[$];     // PCs waiting for decode, head first
  bit          m_iv;       // a response is due at the next edge
  logic [31:0] m_ipc;
  logic [31:0] m_fpc;
  logic [31:0] m_fetched, m_flushed, m_stall;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_im_req", {31'b0, im_req}, 32'd0);
      check("rst_im_addr", im_addr, 32'h0);
      check("rst_id_valid", {31'b0, id_valid}, 32'd0);
      check("rst_id_pcadd4", id_pcadd4, 32'd4);
      check("rst_id_inst", id_inst, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf", perf_fetched | perf_flushed | perf_stall, 32'd0);
`endif
      m_q.delete(); m_iv = 0; m_fpc = 32'h0;
      m_fetched = 0; m_flushed = 0; m_stall = 0;
    end else begin
      automatic bit pop = (m_q.size() != 0) && id_ready;
      automatic int occ = m_q.size() + int'(m_iv) - int'(pop);
      automatic bit exp_req = !loadIM && !redirect && (occ < DEPTH);
      check("im_req", {31'b0, im_req}, {31'b0, exp_req});
      check("im_addr", im_addr, m_fpc);
      check("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        check("id_pc", id_pc, m_q[0]);
        check("id_inst", id_inst, m_q[0] >> 2);
        check("id_pcadd4", id_pcadd4, m_q[0] + 32'd4);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_flushed", perf_flushed, m_flushed);
      check("perf_stall", perf_stall, m_stall);
`endif
      // Advance the model across the coming rising edge.
      if (m_q.size() != 0 && !id_ready) m_stall++;
      if (redirect) begin
        m_flushed += m_q.size() + int'(m_iv);
        m_q.delete();
        m_iv = 0;
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_iv) begin m_q.push_back(m_ipc); m_fetched++; end
        m_iv = exp_req;
        if (exp_req) begin m_ipc = m_fpc; m_fpc = m_fpc + 32'd4; end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset release, streaming with id_ready=1.
    drive(1, 0, 1, 0, 0);
    check("A_rst_addr", im_addr, 32'h0);
    check("A_rst_pcadd4", id_pcadd4, 32'd4);
    drive(0, 0, 1, 0, 0);
    check("A_c0_req", {31'b0, im_req}, 32'd1);
    check("A_c0_addr", im_addr, 32'h0);
    check("A_c0_valid", {31'b0, id_valid}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("A_c1_addr", im_addr, 32'h4);
    check("A_c1_valid", {31'b0, id_valid}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("A_c2_valid", {31'b0, id_valid}, 32'd1);
    check("A_c2_pc", id_pc, 32'h0);
    check("A_c2_inst", id_inst, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("A_c3_pc", id_pc, 32'h4);
    check("A_c3_inst", id_inst, 32'd1);
    check("A_c3_pcadd4", id_pcadd4, 32'h8);

    // Back-pressure: id_ready low for 10 cycles from reset.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);
    check("B_req_stopped", {31'b0, im_req}, 32'd0);
    check("B_head_pc", id_pc, 32'h0);
    check("B_head_inst", id_inst, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 0, 0);
      check("B_resume_pc", id_pc, 32'(4 * k));
    end

    // Full queue, then redirect to 0x103 while decode is ready.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 32'h103);
    check("C_redir_noreq", {31'b0, im_req}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("C_n1_req", {31'b0, im_req}, 32'd1);
    check("C_n1_addr", im_addr, 32'h100);
    check("C_n1_valid", {31'b0, id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("C_flushed", perf_flushed, 32'd4);
`endif
    drive(0, 0, 1, 0, 0);
    check("C_n2_valid", {31'b0, id_valid}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("C_n3_valid", {31'b0, id_valid}, 32'd1);
    check("C_n3_pc", id_pc, 32'h100);
    check("C_n3_inst", id_inst, 32'h40);

    // loadIM for 5 cycles: no requests, queue drains, resume sequentially.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0);
      check("D_no_req", {31'b0, im_req}, 32'd0);
    end
    check("D_drained", {31'b0, id_valid}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("D_resume_req", {31'b0, im_req}, 32'd1);
    check("D_resume_addr", im_addr, 32'h10C);

    // Asynchronous reset mid-cycle with a full queue.
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0);
    check("F_full_valid", {31'b0, id_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("F_async_valid", {31'b0, id_valid}, 32'd0);
    check("F_async_addr", im_addr, 32'h0);
    check("F_async_req", {31'b0, im_req}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("F_restart_req", {31'b0, im_req}, 32'd1);
    check("F_restart_addr", im_addr, 32'h0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    check("F_restart_pc", id_pc, 32'h0);

    // Randomized traffic checked by the model every cycle.
    begin
      int ld_left = 0;
      for (int i = 0; i < 3000; i++) begin
        logic rs, r, rd, ld;
        logic [31:0] rpc;
        rs  = ($urandom_range(0, 999) < 3);
        r   = ($urandom_range(0, 99) < 5);
        rd  = ($urandom_range(0, 99) < 70);
        if (ld_left == 0 && $urandom_range(0, 99) < 4) ld_left = $urandom_range(1, 8);
        ld  = (ld_left != 0);
        if (ld_left != 0) ld_left--;
        rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
        drive(rs, r, rd, ld, rpc);
      end
    end

    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
